instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequences instruction fetch from the byte-wide, asynchronous-read instruction memory. It holds the fetch PC and reads the four bytes of each word over four cycles. It assembles them big-endian (byte at offset 0 is the MSB) and presents the 32-bit instruction to the decode stage over a valid/ready handshake. It sits between the PC/branch logic and the instruction ROM, and owns the ROM address port exclusively.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC values
- ADDR_WIDTH, 10, ROM byte-address width (2^ADDR_WIDTH bytes)
- DATA_WIDTH, 8, ROM data width (one byte per address)
- INSTRUCTION_WIDTH, 32, assembled instruction width (4 × DATA_WIDTH)
- RESET_PC, 0, fetch PC after reset (bits [1:0] ignored)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_en  in  1  load new fetch PC (branch/jump)
- redirect_pc  in  PC_WIDTH  target PC; bits [1:0] ignored
- mem_addr  out  ADDR_WIDTH  ROM byte address
- mem_rdata  in  DATA_WIDTH  ROM byte at mem_addr, same cycle
- instr  out  INSTRUCTION_WIDTH  assembled instruction
- instr_pc  out  PC_WIDTH  word-aligned PC of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts instr this cycle

## Operation
- Registers:
  - fetch_pc, always word-aligned.
  - byte_cnt, 2 bits.
  - state ∈ {FETCH, HOLD}.
  - instr_buf.
- mem_addr = (fetch_pc + byte_cnt) truncated to ADDR_WIDTH bits, so it wraps mod 2^ADDR_WIDTH. It is driven combinationally in both states.
- FETCH:
  - Each cycle, instr_buf <= {instr_buf[23:0], mem_rdata}.
  - byte_cnt increments.
  - When byte_cnt==3, the 4th byte is captured, byte_cnt returns to 0 and state goes to HOLD.
- HOLD:
  - instr_valid=1, instr=instr_buf, instr_pc=fetch_pc.
  - If instr_ready=1: fetch_pc <= fetch_pc+4 (mod 2^PC_WIDTH), state goes to FETCH.
  - Otherwise all registers hold and outputs stay stable.
- instr_valid=0 in FETCH. instr/instr_pc are don't-care while invalid, but must not glitch in HOLD.
- Redirect has priority over everything except rst, in any state:
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - byte_cnt <= 0, state <= FETCH.
  - Any partially assembled word is discarded.
- Redirect in the same cycle as a HOLD handshake: the held instruction counts as accepted; the next fetch starts at the redirect target, not at fetch_pc+4.
- Reset:
  - fetch_pc = {RESET_PC[PC_WIDTH-1:2], 2'b00}.
  - state = FETCH, byte_cnt = 0, instr_buf = 0.
  - instr_valid = 0, instr = 0, instr_pc = aligned RESET_PC.
  - rst overrides redirect_en and handshakes, including mid-fetch or in HOLD.
- No combinational path from instr_ready or redirect_en to instr_valid, instr or instr_pc.

## Timing
- Cycle n = first rising edge with rst low. mem_addr shows fetch_pc+0..+3 during cycles n..n+3; instr_valid rises after edge n+3.
- Fetch latency is 4 cycles. With instr_ready tied high, throughput is one instruction per 5 cycles (4 FETCH + 1 HOLD).
- Redirect sampled at edge k: in cycle k+1, mem_addr = aligned target with byte_cnt 0, and instr_valid = 0. First valid instruction from the target follows after edge k+4.
- Redirect held high for several cycles: fetch restarts each cycle; valid stays low until 4 cycles after the last redirect.
- Backpressure: while instr_valid=1 and instr_ready=0, mem_addr, instr, instr_pc and fetch_pc stay constant.

## Test plan
- Reset with RESET_PC=0, ROM bytes 0x00..0x03 = 13 05 10 00, instr_ready=1:
  - mem_addr 0,1,2,3 in cycles n..n+3.
  - instr_valid first high after edge n+3 with instr=0x13051000, instr_pc=0.
- Back-to-back, ready=1: instr_pc sequence 0x0, 0x4, 0x8; instr_valid high exactly every 5th cycle; instr matches ROM words.
- Backpressure: hold ready=0 for 10 cycles in HOLD, then release.
  - Outputs and mem_addr stable throughout.
  - Exactly one handshake; next instr_pc = previous+4.
- Redirect mid-fetch (byte_cnt=2) with redirect_pc=0x102:
  - Next cycle mem_addr=0x100, valid=0; partial word discarded.
  - Valid after 4 cycles with instr_pc=0x100.
- Redirect + handshake same cycle (HOLD, ready=1, redirect_pc=0x40): next instr_pc=0x40, not old+4.
- Wrap and reset, ADDR_WIDTH=10:
  - Redirect to 0x3FC, accept; next fetch_pc=0x400 drives mem_addr 0x000..0x003.
  - Then assert rst in HOLD: valid drops next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads four bytes per word from an async-read byte ROM,
// assembles them big-endian and hands the word to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned          PC_WIDTH          = 32,
  parameter int unsigned          ADDR_WIDTH        = 10,
  parameter int unsigned          DATA_WIDTH        = 8,
  parameter int unsigned          INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_en,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready
);

  localparam int unsigned         CNT_WIDTH  = 2;
  localparam int unsigned         KEEP_WIDTH = INSTRUCTION_WIDTH - DATA_WIDTH;
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};
  localparam logic [PC_WIDTH-1:0] PC_STEP          = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] LAST_BYTE       = CNT_WIDTH'(3);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
  logic [CNT_WIDTH-1:0]           byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_buf_q, instr_buf_d;

  // Low redirect bits are ignored: targets are always word-aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ROM byte address wraps modulo the ROM size.
  assign mem_addr = ADDR_WIDTH'(fetch_pc_q + PC_WIDTH'(byte_cnt_q));

  // Outputs come straight from flops, so decode never sees a path from ready/redirect.
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_buf_q;
  assign instr_pc    = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC_ALIGNED;
      byte_cnt_q  <= '0;
      instr_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      byte_cnt_q  <= byte_cnt_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    byte_cnt_d  = byte_cnt_q;
    instr_buf_d = instr_buf_q;

    if (redirect_en) begin
      // Redirect wins over fetch and handshake; a partially built word is simply overwritten later.
      fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      byte_cnt_d = '0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          instr_buf_d = {instr_buf_q[KEEP_WIDTH-1:0], mem_rdata};
          byte_cnt_d  = CNT_WIDTH'(byte_cnt_q + CNT_WIDTH'(1));
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a back-to-back cadence sequence.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic [7:0]  rom [0:1023];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          rst;
    bit          red;
    logic [31:0] rpc;
    bit          rdy;
    bit          chk;
    logic [9:0]  e_addr;
    bit          e_valid;
    bit          chk_out;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  assign mem_rdata = rom[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int a);
    logic [31:0] first;
    first = 32'h13051000;
    case (a)
      0: return first[31:24];
      1: return first[23:16];
      2: return first[15:8];
      3: return first[7:0];
      default: return 8'((a * 37 + 11) & 255);
    endcase
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] pc);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w = {w[23:0], pat(int'((pc + 32'(k)) & 32'h3FF))};
    end
    return w;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic row(bit r, bit re, logic [31:0] rpc, bit rdy, bit c, logic [9:0] a,
                     bit v, bit co, logic [31:0] ei, logic [31:0] ep);
    vec_t x;
    x.rst = r; x.red = re; x.rpc = rpc; x.rdy = rdy; x.chk = c;
    x.e_addr = a; x.e_valid = v; x.chk_out = co; x.e_instr = ei; x.e_pc = ep;
    vecs.push_back(x);
  endtask

  task automatic fetch4(logic [31:0] pc);
    for (int k = 0; k < 4; k++) row(0, 0, '0, 1, 1, 10'(pc + 32'(k)), 0, 0, '0, '0);
  endtask

  task automatic hold(logic [31:0] pc, bit rdy, bit re, logic [31:0] rpc);
    row(0, re, rpc, rdy, 1, 10'(pc), 1, 1, word_at(pc), pc);
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = pat(i);

    // Reset, first fetch and back-to-back words
    row(1, 0, '0, 1, 0, '0, 0, 0, '0, '0);
    row(1, 0, '0, 1, 1, 10'h000, 0, 1, 32'h0, 32'h0);
    fetch4(32'h0);  hold(32'h0, 1, 0, '0);
    fetch4(32'h4);  hold(32'h4, 1, 0, '0);
    fetch4(32'h8);
    // Backpressure: ten stalled cycles then one handshake
    for (int i = 0; i < 10; i++) hold(32'h8, 0, 0, '0);
    hold(32'h8, 1, 0, '0);
    fetch4(32'hC);  hold(32'hC, 1, 0, '0);
    // Redirect at byte_cnt==2 to 0x102
    row(0, 0, '0, 1, 1, 10'h010, 0, 0, '0, '0);
    row(0, 0, '0, 1, 1, 10'h011, 0, 0, '0, '0);
    row(0, 1, 32'h102, 1, 1, 10'h012, 0, 0, '0, '0);
    fetch4(32'h100);
    // Redirect together with a handshake
    hold(32'h100, 1, 1, 32'h40);
    fetch4(32'h40); hold(32'h40, 1, 1, 32'h3FC);
    // ROM address wrap
    fetch4(32'h3FC); hold(32'h3FC, 1, 0, '0);
    fetch4(32'h400); hold(32'h400, 0, 0, '0);
    // Reset while holding
    row(1, 1, 32'h80, 1, 1, 10'h000, 1, 1, word_at(32'h400), 32'h400);
    row(0, 0, '0, 1, 1, 10'h000, 0, 1, 32'h0, 32'h0);
    row(0, 0, '0, 1, 1, 10'h001, 0, 0, '0, '0);
    row(0, 0, '0, 1, 1, 10'h002, 0, 0, '0, '0);
    row(0, 0, '0, 1, 1, 10'h003, 0, 0, '0, '0);
    // Redirect held over several cycles
    hold(32'h0, 0, 1, 32'h200);
    row(0, 1, 32'h208, 1, 1, 10'h200, 0, 0, '0, '0);
    row(0, 1, 32'h20C, 1, 1, 10'h208, 0, 0, '0, '0);
    fetch4(32'h20C); hold(32'h20C, 1, 0, '0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; redirect_en = vecs[i].red;
      redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
        if (vecs[i].chk_out) begin
          check($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
          check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_pc);
        end
      end
    end

    // Ready tied high: one valid cycle in every five, consecutive PCs
    rst = 1'b0; redirect_en = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("b2b%0d valid", i), 32'(instr_valid), 32'((i % 5) == 4));
      if ((i % 5) == 4) begin
        check($sformatf("b2b%0d instr_pc", i), instr_pc, 32'h210 + 32'(4 * (i / 5)));
        check($sformatf("b2b%0d instr", i), instr, word_at(32'h210 + 32'(4 * (i / 5))));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
